// File: rtl/sr_drive_pkg.sv
// Shared types and helpers for the S/R stimulus sequencer.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  // Minimal SR excitation {S,R} to move the flip-flop from cur to tgt.
  function automatic logic [1:0] excite(input logic tgt, input logic cur);
    logic [1:0] sr;
    sr = 2'b00;
    if (tgt && !cur) begin
      sr = 2'b10;
    end else if (!tgt && cur) begin
      sr = 2'b01;
    end
    return sr;
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Single-bit command FIFO; push and pop may occur in the same cycle.
module sr_cmd_fifo
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   push_data,
  input  logic                   pop,
  output logic                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count makes its contents irrelevant.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sr_drive_seq.sv
// Drives minimal S/R excitation for queued target Q values, then checks the
// flip-flop's returned Q once the excitation has been held.
module sr_drive_seq
  import sr_drive_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_q,
  output logic       in_ready,
  output logic       S,
  output logic       R,
  input  logic       q_fb,
  output logic       shadow_q,
  output logic       busy,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

  state_t        state_q, state_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          cur_q, cur_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          tgt_q, tgt_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          fifo_pop, fifo_data, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (in_q),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign S        = s_q;
  assign R        = r_q;
  assign shadow_q = cur_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    r_d       = r_q;
    cur_d     = cur_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    tgt_d     = tgt_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (!fifo_empty) begin
          tgt_d      = fifo_data;
          {s_d, r_d} = excite(fifo_data, cur_q);
          hold_d     = HOLD_LOAD;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (q_fb != tgt_q) begin
          err_d = 1'b1;
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        // Track the commanded value, not q_fb, so one fault does not skew
        // the excitation chosen for every later command.
        cur_d   = tgt_q;
        state_d = IDLE;
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      cur_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      r_q       <= r_d;
      cur_q     <= cur_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Loaded on every pop before use, so no reset is needed.
  always_ff @(posedge clk) begin
    tgt_q  <= tgt_d;
    hold_q <= hold_d;
  end

endmodule
